// File: rtl/down_counter_with_load.sv
// Loadable down-counter with an IDLE/COUNT/DONE sequencer, abort, and a
// one-cycle completion pulse. Load values above the modulus are clamped.
module down_counter_with_load #(
    parameter int MAXIMUM_VALUE     = 36,
    parameter int NBITS_FOR_COUNTER = $clog2(MAXIMUM_VALUE)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NBITS_FOR_COUNTER-1:0] load_value,
    input  logic                         enable,
    input  logic                         abort,
    output logic [NBITS_FOR_COUNTER-1:0] count,
    output logic                         busy,
    output logic                         done,
    output logic                         flag0,
    output logic                         flag_max
);

    localparam logic [NBITS_FOR_COUNTER-1:0] MAX_CNT = NBITS_FOR_COUNTER'(MAXIMUM_VALUE - 1);
    localparam logic [NBITS_FOR_COUNTER-1:0] ONE     = NBITS_FOR_COUNTER'(1);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t                         state_q;
    logic [NBITS_FOR_COUNTER-1:0]   count_q;
    logic                           busy_q;
    logic                           done_q;
    logic [NBITS_FOR_COUNTER-1:0]   load_d;
    logic [NBITS_FOR_COUNTER-1:0]   dec_d;

    assign load_d = (load_value > MAX_CNT) ? MAX_CNT : load_value;
    assign dec_d  = count_q - ONE;

    // busy/done are registered alongside the state so they never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        count_q <= load_d;
                        state_q <= COUNT;
                        busy_q  <= 1'b1;
                    end
                end
                COUNT: begin
                    // abort outranks both the zero-exit and the decrement
                    if (abort) begin
                        state_q <= IDLE;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (count_q == '0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (enable) begin
                        count_q <= dec_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count    = count_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign flag0    = (count_q == '0);
    assign flag_max = (count_q == MAX_CNT);

endmodule

// File: tb/tb_down_counter_with_load.sv
// Directed bench for down_counter_with_load (MAXIMUM_VALUE=36, 6-bit count).
module tb_down_counter_with_load;

    logic       clk = 1'b0;
    logic       reset, start, enable, abort;
    logic [5:0] load_value;
    logic [5:0] count;
    logic       busy, done, flag0, flag_max;

    int checks = 0;
    int errors = 0;

    down_counter_with_load #(.MAXIMUM_VALUE(36), .NBITS_FOR_COUNTER(6)) dut (
        .clk(clk), .reset(reset), .start(start), .load_value(load_value),
        .enable(enable), .abort(abort), .count(count), .busy(busy),
        .done(done), .flag0(flag0), .flag_max(flag_max)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; enable = 1'b1; abort = 1'b0; load_value = 6'd20;
        tick();
        tick();
        checks++;
        if ({count, busy, done, flag0, flag_max} !== {6'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got count=%0d busy=%0b done=%0b f0=%0b fmax=%0b want 0/0/0/1/0",
                     count, busy, done, flag0, flag_max);
        end
        reset = 1'b0; start = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [5:0] exp;
        load_value = 6'd5; start = 1'b1; enable = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            exp = 6'(i);
            checks++;
            if ({count, busy, done} !== {exp, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL basic_count: got count=%0d busy=%0b done=%0b want %0d/1/0", count, busy, done, exp);
            end
            if (i != 0) tick();
        end
        tick();
        checks++;
        if ({count, busy, done} !== {6'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL basic_done: got count=%0d busy=%0b done=%0b want 0/0/1", count, busy, done);
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL basic_idle: got busy=%0b done=%0b want 0/0", busy, done);
        end
    endtask

    task automatic test_clamp();
        logic [5:0] vals [4] = '{6'd40, 6'd36, 6'd63, 6'd35};
        for (int i = 0; i < 4; i++) begin
            load_value = vals[i]; start = 1'b1; enable = 1'b0;
            tick();
            start = 1'b0;
            checks++;
            if ({count, flag_max, flag0} !== {6'd35, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL clamp_load: load=%0d got count=%0d fmax=%0b f0=%0b want 35/1/0",
                         vals[i], count, flag_max, flag0);
            end
            enable = 1'b1;
            tick();
            checks++;
            if ({count, flag_max} !== {6'd34, 1'b0}) begin
                errors++;
                $display("FAIL clamp_dec: got count=%0d fmax=%0b want 34/0", count, flag_max);
            end
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end
    endtask

    task automatic test_load_zero();
        load_value = 6'd0; start = 1'b1; enable = 1'b0;
        tick();
        start = 1'b0;
        checks++;
        if ({count, busy, done, flag0} !== {6'd0, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL zero_load: got count=%0d busy=%0b done=%0b want 0/1/0", count, busy, done);
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b01) begin
            errors++;
            $display("FAIL zero_done: got busy=%0b done=%0b want 0/1", busy, done);
        end
        tick();
    endtask

    task automatic test_enable_toggle();
        logic [5:0] exp;
        load_value = 6'd8; start = 1'b1; enable = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            enable = (k % 2 == 0);
            start = (k == 5 || k == 9);
            load_value = 6'd3;
            tick();
            start = 1'b0;
            if (k < 17) begin
                exp = 6'(8 - k / 2);
                checks++;
                if ({count, busy, done} !== {exp, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL toggle_count: edge %0d got count=%0d busy=%0b done=%0b want %0d/1/0",
                             k, count, busy, done, exp);
                end
            end
        end
        checks++;
        if ({count, busy, done} !== {6'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL toggle_done: got count=%0d busy=%0b done=%0b want 0/0/1", count, busy, done);
        end
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL done_ignores_start: got busy=%0b done=%0b want 0/0", busy, done);
        end
    endtask

    task automatic test_abort();
        int done_seen = 0;
        load_value = 6'd10; start = 1'b1; enable = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        checks++;
        if (count !== 6'd3) begin
            errors++;
            $display("FAIL abort_pre: got count=%0d want 3", count);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({count, busy, done, flag0} !== {6'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL abort_idle: got count=%0d busy=%0b done=%0b want 0/0/0", count, busy, done);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done cycles want 0", done_seen);
        end
        load_value = 6'd4; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++;
        if ({count, busy} !== {6'd0, 1'b0}) begin
            errors++;
            $display("FAIL abort_blocks_start: got count=%0d busy=%0b want 0/0", count, busy);
        end
        load_value = 6'd0; start = 1'b1;
        tick();
        start = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL abort_over_zero: got busy=%0b done=%0b want 0/0", busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL abort_over_zero_late: got done=%0b want 0", done);
        end
    endtask

    task automatic test_reset_mid();
        load_value = 6'd12; start = 1'b1; enable = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        checks++;
        if (count !== 6'd7) begin
            errors++;
            $display("FAIL rst_mid_pre: got count=%0d want 7", count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({count, busy, done, flag0} !== {6'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rst_mid: got count=%0d busy=%0b done=%0b want 0/0/0", count, busy, done);
        end
        repeat (3) tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_after: got busy=%0b done=%0b want 0/0", busy, done);
        end
        load_value = 6'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL rst_done_pre: got done=%0b want 1", done);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({count, busy, done} !== {6'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_done: got count=%0d busy=%0b done=%0b want 0/0/0", count, busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL rst_done_after: got done=%0b want 0", done);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp [6] = '{{6'd2, 3'b100}, {6'd1, 3'b100}, {6'd0, 3'b100},
                                {6'd0, 3'b010}, {6'd0, 3'b000}, {6'd2, 3'b100}};
        load_value = 6'd2; start = 1'b1; enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({count, busy, done, 1'b0} !== exp[i]) begin
                errors++;
                $display("FAIL b2b: edge %0d got count=%0d busy=%0b done=%0b want %0d/%0b/%0b",
                         i, count, busy, done, exp[i][8:3], exp[i][2], exp[i][1]);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_load_zero();
        test_enable_toggle();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
